// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode encoding and width limit shared by the LED pattern engine
`timescale 1ns/1ps
package led_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    MODE_ROTL   = 3'd0,
    MODE_ROTR   = 3'd1,
    MODE_BOUNCE = 3'd2,
    MODE_FILL   = 3'd3,
    MODE_BLINK  = 3'd4,
    MODE_HOLD   = 3'd5
  } mode_e;

  // Codes 5..7 all behave as HOLD.
  function automatic mode_e decode_mode(input logic [2:0] m);
    decode_mode = (m > 3'd4) ? MODE_HOLD : mode_e'(m);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - step-rate prescaler with run/pause and single-step gating
`timescale 1ns/1ps
module led_tick_gen
  import led_pkg::*;
#(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             clr_i,
  output logic             step_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] period_m1;
  logic             at_end;

  // div of 0 and 1 both give a terminal count of 0; >= lets a lowered div fire at once.
  assign period_m1 = (div_i == '0) ? '0 : div_i - DIV_W'(1);
  assign at_end    = (cnt_q >= period_m1);

  always_comb begin
    cnt_d  = cnt_q;
    step_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (at_end) begin
        cnt_d  = '0;
        step_o = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      step_o = step_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - programmable-rate LED pattern generator (rotate, bounce, fill, blink, hold)
`timescale 1ns/1ps
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] led_o,
  output logic             tick_o
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [2:0]       mode_q;
  logic             chg_q;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d, seed;
  logic             tick_q;
  logic             step_ev;
  logic             go_up;
  mode_e            cur_mode;

  led_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .div_i  (div_i),
    .run_i  (run_i),
    .step_i (step_i),
    .clr_i  (chg_q),
    .step_o (step_ev)
  );

  assign cur_mode = decode_mode(mode_q);
  // Direction is trusted only while the dot is not already parked at the end it points to.
  assign go_up    = (dir_q == DIR_UP) ? !led_q[WIDTH-1] : led_q[0];

  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    seed  = {{(WIDTH-1){1'b0}}, 1'b1};
    case (cur_mode)
      MODE_ROTL: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      MODE_ROTR: led_d = {led_q[0], led_q[WIDTH-1:1]};
      MODE_BOUNCE: begin
        if (go_up) begin
          led_d = led_q << 1;
          dir_d = led_q[WIDTH-2] ? DIR_DOWN : DIR_UP;
        end else begin
          led_d = led_q >> 1;
          dir_d = led_q[1] ? DIR_UP : DIR_DOWN;
        end
      end
      MODE_FILL:  led_d = (&led_q) ? '0 : {led_q[WIDTH-2:0], 1'b1};
      MODE_BLINK: begin
        led_d = ~led_q;
        seed  = '1;
      end
      MODE_HOLD: seed = led_q;
      default:   seed = led_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 3'(MODE_ROTL);
      chg_q  <= 1'b0;
      dir_q  <= DIR_UP;
      led_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_i;
      chg_q  <= (mode_i != mode_q);
      tick_q <= 1'b0;
      if (chg_q) begin
        led_q <= seed;
        dir_q <= DIR_UP;
      end else if (step_ev) begin
        led_q  <= led_d;
        dir_q  <= dir_d;
        tick_q <= 1'b1;
      end
    end
  end

  assign led_o  = led_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed scoreboard bench for led_pattern_engine at WIDTH=4
`timescale 1ns/1ps
module tb_led_pattern_engine;

  localparam int W  = 4;
  localparam int DW = 25;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [2:0]    mode = 3'd0;
  logic [DW-1:0] div  = DW'(3);
  logic          run  = 1'b1;
  logic          step = 1'b0;
  logic [W-1:0]  led;
  logic          tick;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [W-1:0] led;
    int           gap;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  led_pattern_engine #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode_i (mode),
    .div_i  (div),
    .run_i  (run),
    .step_i (step),
    .led_o  (led),
    .tick_o (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total += 1;
    assert (obs === exp) passed += 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] l, input int gap);
    exp_t e;
    e.led = l;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Pops one expectation per tick; gap is cycles since the previous tick (0 = unchecked).
  task automatic drain(input string tag, input int budget);
    exp_t e;
    int   n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      do begin
        cyc();
        n++;
      end while (!tick && n < budget);
      chk({tag, "_tick"}, 32'(tick), 32'd1);
      chk({tag, "_led"}, 32'(led), 32'(e.led));
      if (e.gap > 0) chk({tag, "_gap"}, 32'(n), 32'(e.gap));
    end
  endtask

  initial begin
    int nt;

    cyc();
    cyc();
    chk("reset_led", 32'(led), 32'h1);
    chk("reset_tick", 32'(tick), 32'h0);
    rst = 1'b0;

    push(4'b0010, 3); push(4'b0100, 3); push(4'b1000, 3); push(4'b0001, 3);
    drain("rotl", 10);

    mode = 3'd2;
    div  = DW'(1);
    cyc();
    cyc();
    chk("bounce_seed", 32'(led), 32'h1);
    chk("bounce_seed_tick", 32'(tick), 32'h0);
    push(4'b0010, 1); push(4'b0100, 1); push(4'b1000, 1); push(4'b0100, 1);
    push(4'b0010, 1); push(4'b0001, 1); push(4'b0010, 1);
    drain("bounce", 4);

    mode = 3'd3;
    div  = DW'(2);
    cyc();
    cyc();
    chk("fill_seed", 32'(led), 32'h1);
    push(4'b0011, 2); push(4'b0111, 2); push(4'b1111, 2); push(4'b0000, 2); push(4'b0001, 2);
    drain("fill", 6);

    mode = 3'd4;
    cyc();
    cyc();
    chk("blink_seed", 32'(led), 32'hF);
    chk("blink_seed_tick", 32'(tick), 32'h0);
    push(4'b0000, 2); push(4'b1111, 2);
    drain("blink", 6);

    run  = 1'b0;
    div  = DW'(5);
    mode = 3'd0;
    cyc();
    cyc();
    chk("pause_seed", 32'(led), 32'h1);
    nt = 0;
    repeat (20) begin
      cyc();
      if (tick) nt++;
    end
    chk("pause_no_tick", 32'(nt), 32'd0);
    chk("pause_led", 32'(led), 32'h1);

    push(4'b0010, 0); push(4'b0100, 0); push(4'b1000, 0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("step_tick", 32'(tick), 32'h1);
      chk("step_led", 32'(led), 32'(e.led));
      cyc();
      chk("step_tick_low", 32'(tick), 32'h0);
      cyc();
    end

    run  = 1'b1;
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("run_step_ignored_tick", 32'(tick), 32'h0);
    chk("run_step_ignored_led", 32'(led), 32'h8);

    mode = 3'd1;
    div  = DW'(10);
    cyc();
    cyc();
    chk("rotr_seed", 32'(led), 32'h1);
    nt = 0;
    repeat (6) begin
      cyc();
      if (tick) nt++;
    end
    chk("div10_no_tick", 32'(nt), 32'd0);
    div = DW'(2);
    push(4'b1000, 1); push(4'b0100, 2); push(4'b0010, 2);
    drain("div_drop", 12);

    div = DW'(10);
    cyc();
    cyc();
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'h1);
    chk("async_rst_tick", 32'(tick), 32'h0);

    mode = 3'd6;
    div  = DW'(3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    cyc();
    chk("hold_seed", 32'(led), 32'h1);
    push(4'b0001, 3); push(4'b0001, 3); push(4'b0001, 3);
    drain("hold", 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
